// File: rtl/bounce_gen_pkg.sv
// Shared constants for the switch-bounce emulator: state codes, LFSR taps and seed helpers.
package bounce_gen_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_GLITCH_ON  = 2'd1;
  localparam logic [1:0] ST_GLITCH_OFF = 2'd2;
  localparam logic [1:0] ST_SETTLE     = 2'd3;

  // x^8+x^6+x^5+x^4+1 expressed as a mask over the shift register stages
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  function automatic logic [7:0] lfsr_seed_fix(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_gen_if.sv
// Level-in / bouncing-level-out bundle between a stimulus source and the bounce emulator.
interface bounce_gen_if;
  logic clean_in;
  logic bounce_out;
  logic busy;
  logic done;

  modport master (output clean_in, input bounce_out, input busy, input done);
  modport slave  (input clean_in, output bounce_out, output busy, output done);
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shifts every cycle; absent when BOUNCE_GEN_FIXED_EN is defined.
`ifndef BOUNCE_GEN_FIXED_EN
module lfsr8
  import bounce_gen_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_lfsr
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= lfsr_seed_fix(SEED);
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule
`endif

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns each clean level change into glitch pairs plus a settle period.
// Define BOUNCE_GEN_FIXED_EN for maximal, LFSR-free (deterministic) gaps and bounce counts.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int unsigned GAP_W      = 2,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned SETTLE_CYC = 8,
  parameter logic [7:0]  SEED       = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         rst,
  bounce_gen_if.slave  bif
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [1:0]       r_state;
  logic             r_bounce;
  logic             r_stable;
  logic             r_target;
  logic             r_busy;
  logic             r_done;
  logic [GAP_W-1:0] r_gap;
  logic [CNT_W:0]   r_bnc;
  logic [SET_W-1:0] r_settle;

  logic [GAP_W-1:0] w_gap_load;
  logic [CNT_W:0]   w_bnc_load;
  logic             w_restart;

`ifdef BOUNCE_GEN_FIXED_EN
  assign w_gap_load = '1;
  assign w_bnc_load = (CNT_W + 1)'(2 ** CNT_W);
`else
  logic [7:0] w_lfsr;
  logic       w_unused_lfsr;

  lfsr8 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  assign w_gap_load    = w_lfsr[GAP_W-1:0];
  assign w_bnc_load    = {1'b0, w_lfsr[GAP_W+CNT_W-1:GAP_W]} + (CNT_W + 1)'(1);
  assign w_unused_lfsr = ^w_lfsr;
`endif

  // A level change against whatever we are heading for (re)starts the sequence.
  assign w_restart = (r_state == ST_IDLE) ? (bif.clean_in != r_stable)
                                          : (bif.clean_in != r_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bounce <= 1'b0;
      r_stable <= 1'b0;
      r_target <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_gap    <= '0;
      r_bnc    <= '0;
      r_settle <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_restart) begin
        r_target <= bif.clean_in;
        r_bounce <= bif.clean_in;
        r_gap    <= w_gap_load;
        r_bnc    <= w_bnc_load;
        r_state  <= ST_GLITCH_ON;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          ST_GLITCH_ON: begin
            if (r_gap == '0) begin
              r_state  <= ST_GLITCH_OFF;
              r_bounce <= ~r_target;
              r_gap    <= w_gap_load;
            end else begin
              r_gap <= r_gap - GAP_W'(1);
            end
          end
          ST_GLITCH_OFF: begin
            if (r_gap == '0) begin
              r_bnc    <= r_bnc - (CNT_W + 1)'(1);
              r_bounce <= r_target;
              if (r_bnc == (CNT_W + 1)'(1)) begin
                r_state  <= ST_SETTLE;
                r_settle <= SET_W'(SETTLE_CYC - 1);
              end else begin
                r_state <= ST_GLITCH_ON;
                r_gap   <= w_gap_load;
              end
            end else begin
              r_gap <= r_gap - GAP_W'(1);
            end
          end
          ST_SETTLE: begin
            if (r_settle == '0) begin
              r_state  <= ST_IDLE;
              r_stable <= r_target;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_settle <= r_settle - SET_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bif.bounce_out = r_bounce;
  assign bif.busy       = r_busy;
  assign bif.done       = r_done;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: a waveform-schedule model checked every cycle, plus literal waveforms.
module tb_bounce_gen;

  localparam int unsigned GAP_W      = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned SETTLE_CYC = 8;
  localparam logic [7:0]  SEED_A     = 8'hA5;
  localparam logic [7:0]  SEED_Z     = 8'h00;

`ifdef BOUNCE_GEN_FIXED_EN
  localparam logic [15:0] LIT_A_BNC  = 16'h0F0F;
  localparam logic [15:0] LIT_A_DONE = 16'h0000;
  localparam logic [11:0] LIT_Z_BNC  = 12'hF0F;
  localparam logic [11:0] LIT_Z_DONE = 12'h000;
`else
  // A5: 2 pairs, gaps 2/2/1/2, settle edges 7..14, done at edge 15
  localparam logic [15:0] LIT_A_BNC  = 16'hFF93;
  localparam logic [15:0] LIT_A_DONE = 16'h8000;
  // 01: 1 pair, gaps 2/1, settle edges 3..10, done at edge 11
  localparam logic [11:0] LIT_Z_BNC  = 12'hFFB;
  localparam logic [11:0] LIT_Z_DONE = 12'h800;
`endif

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_z = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  bounce_gen_if bif_a ();
  bounce_gen_if bif_z ();

  bounce_gen #(
    .GAP_W (GAP_W), .CNT_W (CNT_W), .SETTLE_CYC (SETTLE_CYC), .SEED (SEED_A)
  ) dut_a (
    .clk (clk), .rst (rst_a), .bif (bif_a)
  );

  bounce_gen #(
    .GAP_W (GAP_W), .CNT_W (CNT_W), .SETTLE_CYC (SETTLE_CYC), .SEED (SEED_Z)
  ) dut_z (
    .clk (clk), .rst (rst_z), .bif (bif_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: whole waveform scheduled at the sampling edge ----------------
  logic [2:0] m_sched [2][64];  // {done, busy, bounce} per edge
  int         m_len   [2];
  int         m_pos   [2];
  logic       m_stable[2];
  logic       m_target[2];
  logic [7:0] m_lfsr  [2];
  logic [2:0] m_exp   [2];

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] ahead(input logic [7:0] v, input int n);
    logic [7:0] x = v;
    for (int i = 0; i < n; i++) x = step(x);
    return x;
  endfunction

  function automatic int gap_len(input logic [7:0] v);
`ifdef BOUNCE_GEN_FIXED_EN
    return 2 ** GAP_W + 0 * int'(v);
`else
    return int'(v) % (2 ** GAP_W) + 1;
`endif
  endfunction

  function automatic int pair_cnt(input logic [7:0] v);
`ifdef BOUNCE_GEN_FIXED_EN
    return 2 ** CNT_W + 0 * int'(v);
`else
    return (int'(v) >> GAP_W) % (2 ** CNT_W) + 1;
`endif
  endfunction

  task automatic build(input int k, input logic lvl);
    int n = 0;
    logic [7:0] l0 = m_lfsr[k];
    m_target[k] = lvl;
    for (int p = 0; p < pair_cnt(l0); p++) begin
      for (int h = 0; h < 2; h++) begin
        int g;
        g = gap_len(ahead(l0, n));
        for (int c = 0; c < g; c++) begin
          m_sched[k][n] = {2'b01, (h == 0) ? lvl : ~lvl};
          n++;
        end
      end
    end
    for (int c = 0; c < int'(SETTLE_CYC); c++) begin
      m_sched[k][n] = {2'b01, lvl};
      n++;
    end
    m_sched[k][n] = {2'b10, lvl};
    m_len[k] = n + 1;
    m_pos[k] = 0;
  endtask

  task automatic model_edge(input int k, input logic r, input logic c);
    logic ref_lvl;
    if (r) begin
      m_lfsr[k]   = (k == 0) ? SEED_A : 8'h01;  // zero seed runs as 01
      m_len[k]    = 0;
      m_pos[k]    = 0;
      m_stable[k] = 1'b0;
      m_target[k] = 1'b0;
      m_exp[k]    = 3'b000;
      return;
    end
    ref_lvl = (m_pos[k] < m_len[k]) ? m_target[k] : m_stable[k];
    if (c != ref_lvl) build(k, c);
    if (m_pos[k] < m_len[k]) begin
      m_exp[k] = m_sched[k][m_pos[k]];
      m_pos[k]++;
      if (m_exp[k][2]) m_stable[k] = m_target[k];
    end else begin
      m_exp[k] = {2'b00, m_stable[k]};
    end
    m_lfsr[k] = step(m_lfsr[k]);
  endtask

  always @(posedge clk) begin
    model_edge(0, rst_a, bif_a.clean_in);
    model_edge(1, rst_z, bif_z.clean_in);
  end

  always @(negedge clk) begin
    check("wave_a", 16'({bif_a.done, bif_a.busy, bif_a.bounce_out}),
          rst_a ? 16'h0 : 16'(m_exp[0]));
    check("wave_z", 16'({bif_z.done, bif_z.busy, bif_z.bounce_out}),
          rst_z ? 16'h0 : 16'(m_exp[1]));
  end

  // ---------------- stimulus ----------------
  logic [15:0] cap_b;
  logic [15:0] cap_d;
  int          done_cnt;
  logic        found;
  int          holds [8] = '{5, 2, 1, 12, 45, 3, 9, 60};

  initial begin
    bif_a.clean_in = 1'b1;
    bif_z.clean_in = 1'b0;
    #3;
    check("reset_a", 16'({bif_a.done, bif_a.busy, bif_a.bounce_out}), 16'h0);
    check("reset_z", 16'({bif_z.done, bif_z.busy, bif_z.bounce_out}), 16'h0);

    // clean_in already high at release: the rise starts on the first edge
    repeat (3) @(negedge clk);
    #2 rst_a = 1'b0;
    cap_b = '0;
    cap_d = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      cap_b[i] = bif_a.bounce_out;
      cap_d[i] = bif_a.done;
    end
    check("first_rise_bounce", cap_b, LIT_A_BNC);
    check("first_rise_done", cap_d, LIT_A_DONE);

    @(negedge clk);
    #2;
    // short holds force restarts mid-sequence
    for (int i = 0; i < 8; i++) begin
      bif_a.clean_in = ~bif_a.clean_in;
      repeat (holds[i]) @(negedge clk);
      #2;
    end

    done_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      bif_a.clean_in = ~bif_a.clean_in;
      repeat (100) begin
        @(negedge clk);
        if (bif_a.done) done_cnt++;
      end
      #2;
    end
    check("done_pulses", 16'(done_cnt), 16'd200);
    check("final_level", 16'({bif_a.busy, bif_a.bounce_out}), 16'({1'b0, bif_a.clean_in}));

    // zero-seed instance: reset in the middle of a low glitch
    rst_z = 1'b0;
    repeat (4) @(negedge clk);
    #2 bif_z.clean_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bif_z.busy && !bif_z.bounce_out) found = 1'b1;
    end
    check("z_glitch_off_seen", 16'(found), 16'h1);
    #2 rst_z = 1'b1;
    #1;
    check("z_async_reset", 16'({bif_z.done, bif_z.busy, bif_z.bounce_out}), 16'h0);
    repeat (2) @(negedge clk);
    #2 rst_z = 1'b0;
    cap_b = '0;
    cap_d = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      cap_b[i] = bif_z.bounce_out;
      cap_d[i] = bif_z.done;
    end
    check("z_rise_bounce", 16'(cap_b[11:0]), 16'(LIT_Z_BNC));
    check("z_rise_done", 16'(cap_d[11:0]), 16'(LIT_Z_DONE));

    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!bif_z.busy) found = 1'b1;
    end
    check("z_settled", 16'({found, bif_z.bounce_out}), 16'h3);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Switch-bounce emulator: converts a clean level on clean_in into a realistic bouncing waveform on bounce_out.
- Drives the input of the debouncer in self-checking benches and in on-board loopback tests, where it sits directly in front of the debouncer.
- Bounce count and glitch widths come from an internal 8-bit LFSR.
- Every transition settles to the clean level and is followed by a guaranteed quiet period.

Parameters:
- GAP_W, 2: width of the glitch-gap field; each glitch segment lasts 1..2^GAP_W cycles.
- CNT_W, 2: width of the bounce-count field; 1..2^CNT_W glitch pairs per transition.
- SETTLE_CYC, 8: cycles bounce_out is held at the target level after the last glitch.
- SEED, 8'hA5: LFSR reset value; a value of 0 is replaced by 8'h01.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clean_in  in  1  ideal switch level to emulate
- bounce_out  out  1  bouncing version of clean_in (registered)
- busy  out  1  high while a bounce/settle sequence is in progress
- done  out  1  one-cycle pulse when the output has settled and the sequence returns to IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE; bounce_out=0, stable=0, target=0, busy=0, done=0.
  - lfsr=SEED (8'h01 if SEED==0); gap_cnt=0, bnc_left=0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every clock when not in reset; never reaches 0.
- IDLE:
  - bounce_out=stable.
  - If clean_in!=stable at a rising edge, at that edge: target<=clean_in, bounce_out<=clean_in, gap_cnt<=lfsr[GAP_W-1:0], bnc_left<=lfsr[GAP_W+CNT_W-1:GAP_W]+1, state<=GLITCH_ON.
  - Latency from sampling edge to first bounce_out change: 0 cycles (output updates on the same edge).
- GLITCH_ON: bounce_out=target.
  - Lasts gap_cnt+1 cycles.
  - On expiry: state<=GLITCH_OFF, bounce_out<=~target, gap_cnt reloaded from lfsr.
- GLITCH_OFF: bounce_out=~target.
  - Lasts gap_cnt+1 cycles.
  - On expiry, bnc_left decrements.
  - If the result is 0: state<=SETTLE, bounce_out<=target, settle counter loaded with SETTLE_CYC-1.
  - Otherwise: state<=GLITCH_ON, bounce_out<=target, gap reloaded.
- SETTLE: bounce_out=target.
  - Lasts SETTLE_CYC cycles.
  - On expiry: state<=IDLE, stable<=target, done<=1 for exactly one cycle.
- busy = (state!=IDLE), registered together with the state.
- Target flip mid-sequence: in any non-IDLE state, if clean_in!=target at an edge, the sequence restarts immediately.
  - Same actions as the IDLE entry, using the new clean_in; no done pulse.
- Reset mid-sequence: the sequence is aborted asynchronously and all outputs go to their reset values.
  - If clean_in=1 when rst deasserts, a rising sequence starts on the first edge (stable=0).
- Widths: all counters saturate-free, loaded only from the LFSR fields described above; no wrap beyond field width.

Optional Feature:
- Macro: BOUNCE_GEN_FIXED_EN.
- Defined: LFSR not instantiated.
  - Every gap = 2^GAP_W cycles.
  - Every transition has exactly 2^CNT_W glitch pairs.
  - Fully deterministic waveform for golden-waveform benches.
- Undefined: LFSR-driven random gaps and counts as above.

Decomposition:
- Shared package/header bounce_gen_pkg:
  - state encoding IDLE=2'd0, GLITCH_ON=2'd1, GLITCH_OFF=2'd2, SETTLE=2'd3.
  - LFSR tap mask 8'hB8.
  - default SEED.
- One sub-module: lfsr8 (8-bit Fibonacci LFSR; seed parameter; async active-high reset; shifts every cycle).
  - Excluded when BOUNCE_GEN_FIXED_EN is defined.

Test Plan:
- Fixed mode, defaults, rst released, clean_in 0->1 sampled at edge E0:
  - bounce_out=1 for E0..E3 and 0 for E4..E7, repeated 4 times.
  - SETTLE with bounce_out=1 from E32; done=1 for one cycle after E40.
  - busy high E0..E40.
- Fixed mode, after settle at 1, clean_in 1->0:
  - Mirror waveform (0 four cycles, 1 four cycles, x4), then 8 cycles at 0.
  - done pulse; final bounce_out=0.
- Fixed mode, clean_in returns 1->0 at E10 during a rising sequence:
  - Sequence restarts at E10 with bounce_out=0 and target=0.
  - No done pulse for the aborted rise; done only after the falling sequence completes (E50).
- Random mode, SEED=8'hA5, 200 toggles of clean_in, each held 100 cycles:
  - Every sequence has 1..4 glitch pairs and gaps 1..4 cycles.
  - Final level equals clean_in; exactly one done pulse per completed sequence.
- SEED=0 and rst asserted mid-GLITCH_OFF:
  - bounce_out, busy and done go to 0 asynchronously; LFSR restarts at 8'h01 and is never 0.
  - With clean_in=1 at rst release, a new rising sequence starts on the first edge.
